datmem_be: RTL and testbench
============================

# datmem_be

Byte-addressable, parametrised data memory for the MEM stage of the in-order pipeline. Supports RV32I load/store widths (byte, half, word) with sign/zero extension. Flags misaligned, out-of-range and illegal-width accesses instead of silently corrupting memory. Replaces one-shot reset clearing with a one-word-per-cycle clear sweep and a `busy` flag, so depth scales without a WORDS-wide reset fan-out.

## Interface

Parameters:
- `WORDS`, 256: depth in 32-bit words; power of two, ≥ 2.
- `ADDR_W`, 32: byte-address width; must be ≥ clog2(WORDS)+2.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  1  access request this cycle.
- `mem_wrt`  in  1  1 = store, 0 = load; qualified by `req`.
- `funct3`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `mem_ad`  in  ADDR_W  byte address.
- `writ_dat`  in  32  store data; low bytes used for B/H.
- `red_dat`  out  32  load result, extended to 32 bits.
- `rd_vld`  out  1  one-cycle pulse: `red_dat` updated by a load.
- `err`  out  1  one-cycle pulse: previous request was rejected.
- `busy`  out  1  clear sweep in progress; requests ignored.

## Operation

- State machine has two states: CLEAR and IDLE.
- Reset (`rst`=1 at a rising edge):
  - state ← CLEAR, sweep pointer ← 0.
  - `red_dat` ← 0, `rd_vld` ← 0, `err` ← 0, `busy` ← 1.
- CLEAR:
  - Each cycle with `rst`=0: `mem[ptr]` ← 0, ptr ← ptr+1.
  - After writing word WORDS−1: state ← IDLE, `busy` ← 0.
  - `req` is ignored entirely: no write, no `rd_vld`, no `err`.
  - `rst` reasserted mid-sweep restarts the sweep at word 0.
- IDLE: a request is accepted when `req`=1. It is rejected (`err` next cycle, memory untouched, `rd_vld`=0) if any of these hold:
  - `mem_ad[ADDR_W-1 : clog2(WORDS)+2]` ≠ 0 (out of range).
  - `funct3` ∉ {000, 001, 010, 100, 101}.
  - Store with `funct3` 100 or 101.
  - H/HU with `mem_ad[0]`=1.
  - W with `mem_ad[1:0]` ≠ 00.
- Word index = `mem_ad[clog2(WORDS)+1 : 2]`; lane = `mem_ad[1:0]`.
- Store writes by byte enables:
  - SB: only lane `mem_ad[1:0]` ← `writ_dat[7:0]`.
  - SH: lanes {2·`mem_ad[1]`, +1} ← `writ_dat[15:0]`.
  - SW: all four lanes ← `writ_dat`.
  - Other bytes of the word are preserved.
- Load extraction:
  - Selects the byte or halfword at the lane.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W returns the word unchanged.
- `red_dat` holds its value across stores, rejected requests and idle cycles. It changes only on a successful load, or on reset (to 0).
- `rd_vld` and `err` are never both 1.

## Timing

- Clear sweep: `busy`=1 from the reset edge through the WORDS-th cycle after `rst` falls; IDLE from cycle WORDS+1.
- Load latency is 1: request sampled at edge N; `red_dat`/`rd_vld` valid after edge N (cycle N+1).
- Store takes effect at edge N. A load sampled at edge N+1 to the same word returns the new data.
- Throughput is one request per cycle. Back-to-back loads give back-to-back `rd_vld` pulses.
- `err` asserts in the cycle after the rejected request, for one cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Reset with WORDS=16, hold `rst` 2 cycles then release → `busy`=1 for exactly 16 cycles after release; then LW of every address returns 0 with `rd_vld` pulses; `red_dat`=0 during reset.
- SW 0x8001_7F80 @0x4; LB @0x4 → 0xFFFF_FF80; LBU @0x4 → 0x0000_0080; LH @0x6 → 0xFFFF_8001; LHU @0x4 → 0x0000_7F80.
- SW 0x1122_3344 @0x8; SB 0xAA @0xA; SH 0xBEEF @0x8; LW @0x8 → 0x11AA_BEEF.
- Misaligned LW @0x2, SH @0x5 → `err` pulse each; memory unchanged; `red_dat` keeps its prior value; `rd_vld`=0.
- Out of range with WORDS=16 (LW @0x40) and illegal `funct3`=011 → `err` pulse, no access. Store with `funct3`=100 → `err`, no write.
- Reassert `rst` mid-sweep at pointer 7 → sweep restarts; `busy` held a full WORDS cycles after release. `req` during `busy` → no `rd_vld`/`err`, memory unchanged.

Source files
------------

// File: rtl/datmem_be_if.sv
// datmem_be_if: request/response bus between the MEM stage and datmem_be.
interface datmem_be_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              mem_wrt;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] mem_ad;
  logic [31:0]       writ_dat;
  logic [31:0]       red_dat;
  logic              rd_vld;
  logic              err;
  logic              busy;
  modport master(output req, mem_wrt, funct3, mem_ad, writ_dat, input red_dat, rd_vld, err, busy);
  modport slave(input req, mem_wrt, funct3, mem_ad, writ_dat, output red_dat, rd_vld, err, busy);
endinterface

// File: rtl/datmem_be.sv
// datmem_be: byte-enabled RV32I data memory with a one-word-per-cycle clear sweep after reset.
module datmem_be #(
  parameter int WORDS  = 256,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  datmem_be_if.slave bus
);
  localparam int IW = $clog2(WORDS);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t      r_state;
  logic [IW-1:0] r_ptr;
  logic [31:0] r_mem [WORDS];
  logic [31:0] r_red;
  logic        r_rdv, r_err, r_busy;
  logic [IW-1:0] w_idx;
  logic [1:0]  w_lane;
  logic [31:0] w_word, w_wd, w_ld;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic [3:0]  w_be;
  logic        w_bad;
  always_comb begin
    w_idx  = bus.mem_ad[IW+1:2];
    w_lane = bus.mem_ad[1:0];
    w_word = r_mem[w_idx];
    w_b    = 8'(w_word >> {w_lane, 3'b000});
    w_h    = w_lane[1] ? w_word[31:16] : w_word[15:0];
    w_bad  = (|(bus.mem_ad >> (IW + 2)))
           || !(bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
           || (bus.mem_wrt && bus.funct3[2])
           || (bus.funct3[1:0] == 2'b01 && bus.mem_ad[0])
           || (bus.funct3[1:0] == 2'b10 && |w_lane);
    w_be   = bus.funct3[1:0] == 2'b00 ? 4'b0001 << w_lane :
             bus.funct3[1:0] == 2'b01 ? 4'b0011 << {w_lane[1], 1'b0} : 4'b1111;
    w_wd   = bus.funct3[1:0] == 2'b00 ? {4{bus.writ_dat[7:0]}} :
             bus.funct3[1:0] == 2'b01 ? {2{bus.writ_dat[15:0]}} : bus.writ_dat;
    w_ld   = bus.funct3 == 3'b000 ? {{24{w_b[7]}}, w_b} :
             bus.funct3 == 3'b001 ? {{16{w_h[15]}}, w_h} :
             bus.funct3 == 3'b100 ? {24'd0, w_b} :
             bus.funct3 == 3'b101 ? {16'd0, w_h} : w_word;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_red   <= '0;
      r_rdv   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_rdv <= 1'b0;
      r_err <= 1'b0;
      if (r_state == CLEAR) begin
        r_mem[r_ptr] <= '0;
        r_ptr        <= r_ptr + 1'b1;
        if (r_ptr == IW'(WORDS - 1)) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      end else if (bus.req) begin
        if (w_bad) r_err <= 1'b1;
        else if (bus.mem_wrt) begin
          for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
        end else begin
          r_red <= w_ld;
          r_rdv <= 1'b1;
        end
      end
    end
  end
  assign bus.red_dat = r_red;
  assign bus.rd_vld  = r_rdv;
  assign bus.err     = r_err;
  assign bus.busy    = r_busy;
endmodule

// File: tb/tb_datmem_be.sv
// tb_datmem_be: directed and random accesses checked against a byte-array reference model.
module tb_datmem_be;
  localparam int WORDS = 16;
  localparam int BYTES = WORDS * 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, passes = 0;
  logic [7:0]  m [BYTES];
  logic [31:0] exp_red = '0;
  datmem_be_if #(.ADDR_W(32)) bus ();
  datmem_be #(.WORDS(WORDS), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
  endfunction

  function automatic bit rejected(input bit wrt, input logic [2:0] f3, input logic [31:0] ad);
    if (ad >= BYTES) return 1;
    if (!(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1;
    if (wrt && f3 >= 4) return 1;
    if (ad % nbytes(f3) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] ad);
    logic [31:0] v = '0;
    for (int i = 0; i < nbytes(f3); i++) v = v + (32'(m[ad + i]) << (8 * i));
    if (f3 == 0 && v >= 32'h80) v = v - 32'h100;
    if (f3 == 1 && v >= 32'h8000) v = v - 32'h10000;
    return v;
  endfunction

  task automatic access(input bit wrt, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd);
    bit bad;
    bus.req = 1'b1; bus.mem_wrt = wrt; bus.funct3 = f3; bus.mem_ad = ad; bus.writ_dat = wd;
    bad = rejected(wrt, f3, ad);
    step();
    bus.req = 1'b0;
    if (!bad && wrt)
      for (int i = 0; i < nbytes(f3); i++) m[ad + i] = 8'(wd >> (8 * i));
    if (!bad && !wrt) exp_red = model_load(f3, ad);
    check("err", 32'(bus.err), 32'(bad));
    check("rd_vld", 32'(bus.rd_vld), 32'(!bad && !wrt));
    check("red_dat", bus.red_dat, exp_red);
  endtask

  task automatic sweep_wait();
    int cnt = 0;
    bus.req = 1'b1; bus.mem_wrt = 1'b1; bus.funct3 = 3'b010; bus.mem_ad = 32'h0; bus.writ_dat = 32'hDEAD_BEEF;
    while (bus.busy === 1'b1 && cnt < 100) begin
      check("busy_rd_vld", 32'(bus.rd_vld), 32'd0);
      check("busy_err", 32'(bus.err), 32'd0);
      cnt++;
      step();
    end
    bus.req = 1'b0;
    check("busy_cycles", 32'(cnt), 32'(WORDS));
    for (int i = 0; i < BYTES; i++) m[i] = 8'h00;
  endtask

  initial begin
    bus.req = 1'b0; bus.mem_wrt = 1'b0; bus.funct3 = 3'b010; bus.mem_ad = '0; bus.writ_dat = '0;
    step();
    step();
    check("rst_red_dat", bus.red_dat, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_rd_vld", 32'(bus.rd_vld), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    sweep_wait();
    exp_red = '0;
    for (int a = 0; a < BYTES; a += 4) access(0, 3'b010, 32'(a), 0);
    access(1, 3'b010, 32'h4, 32'h8001_7F80);
    access(0, 3'b000, 32'h4, 0); check("lb", bus.red_dat, 32'hFFFF_FF80);
    access(0, 3'b100, 32'h4, 0); check("lbu", bus.red_dat, 32'h0000_0080);
    access(0, 3'b001, 32'h6, 0); check("lh", bus.red_dat, 32'hFFFF_8001);
    access(0, 3'b101, 32'h4, 0); check("lhu", bus.red_dat, 32'h0000_7F80);
    access(1, 3'b010, 32'h8, 32'h1122_3344);
    access(1, 3'b000, 32'hA, 32'h0000_00AA);
    access(1, 3'b001, 32'h8, 32'h0000_BEEF);
    access(0, 3'b010, 32'h8, 0); check("merge", bus.red_dat, 32'h11AA_BEEF);
    access(0, 3'b010, 32'h2, 0);
    access(1, 3'b001, 32'h5, 32'h0000_5555);
    access(0, 3'b010, 32'h40, 0);
    access(0, 3'b011, 32'h0, 0);
    access(1, 3'b100, 32'h8, 32'h0000_0077);
    check("keep_red", bus.red_dat, 32'h11AA_BEEF);
    access(0, 3'b010, 32'h4, 0); check("unchanged4", bus.red_dat, 32'h8001_7F80);
    access(0, 3'b010, 32'h8, 0); check("unchanged8", bus.red_dat, 32'h11AA_BEEF);
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ad;
      ad = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(BYTES, 1023)) : 32'($urandom_range(0, BYTES - 1));
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ad, $urandom);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    check("restart_red_dat", bus.red_dat, 32'h0);
    rst = 1'b0;
    sweep_wait();
    exp_red = '0;
    for (int a = 0; a < BYTES; a += 4) access(0, 3'b010, 32'(a), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
